coin_array: RTL and testbench

COIN_ARRAY -- requirements
Module: coin_array

---
 rtl/coin_pkg.sv | 19 +
 rtl/coin_slot.sv | 100 ++++++++++
 rtl/coin_array.sv | 138 +++++++++++++
 tb/tb_coin_array.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coin_pkg.sv
// Shared constants and helpers for the coin array.
// Default sprite/hitbox sizes and saturating score add.
package coin_pkg;

  localparam int COIN_W_D   = 16;
  localparam int COIN_H_D   = 28;
  localparam int PLAYER_W_D = 16;
  localparam int PLAYER_H_D = 32;

  function automatic logic [7:0] sat_add8(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/coin_slot.sv
// One coin slot: alive flag, animation, respawn timer,
// player overlap test and pixel hit/offset.
module coin_slot
  import coin_pkg::*;
#(
  parameter int N_FRAMES      = 3,
  parameter int FRAME_HOLD    = 4,
  parameter int RESPAWN_TICKS = 0,
  parameter int CX            = 400,
  parameter int COIN_Y        = 300,
  parameter int COIN_W        = COIN_W_D,
  parameter int COIN_H        = COIN_H_D,
  parameter int PLAYER_W      = PLAYER_W_D,
  parameter int PLAYER_H      = PLAYER_H_D,
  parameter int FW            = 2,
  parameter int SXW           = 4,
  parameter int SYW           = 5
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_tick,
  input  logic [9:0]     i_px,
  input  logic [9:0]     i_py,
  input  logic [10:0]    i_wx,
  input  logic [10:0]    i_wy,
  output logic           o_alive,
  output logic [FW-1:0]  o_frame,
  output logic           o_eat,
  output logic           o_hit,
  output logic [SXW-1:0] o_sx,
  output logic [SYW-1:0] o_sy
);

  localparam logic [10:0]   L_CX   = 11'(CX);
  localparam logic [10:0]   L_CXE  = 11'(CX + COIN_W - 1);
  localparam logic [10:0]   L_CY   = 11'(COIN_Y);
  localparam logic [10:0]   L_CYE  = 11'(COIN_Y + COIN_H - 1);
  localparam logic [7:0]    L_HMAX = 8'(FRAME_HOLD - 1);
  localparam logic [FW-1:0] L_FMAX = FW'(N_FRAMES - 1);
  localparam logic [15:0]   L_RMAX = 16'(RESPAWN_TICKS - 1);

  logic          r_alive;
  logic [FW-1:0] r_frame;
  logic [7:0]    r_hold;
  logic [15:0]   r_resp;

  logic [10:0] w_px;
  logic [10:0] w_py;
  logic        w_ov;

  assign w_px = {1'b0, i_px};
  assign w_py = {1'b0, i_py};

  assign w_ov = (L_CX < w_px + 11'(PLAYER_W))
             && (w_px < L_CX + 11'(COIN_W))
             && (L_CY < w_py + 11'(PLAYER_H))
             && (w_py < L_CY + 11'(COIN_H));

  assign o_eat   = i_tick & r_alive & w_ov;
  assign o_alive = r_alive;
  assign o_frame = r_frame;

  assign o_hit = r_alive
              && (i_wx >= L_CX) && (i_wx <= L_CXE)
              && (i_wy >= L_CY) && (i_wy <= L_CYE);
  assign o_sx  = o_hit ? SXW'(i_wx - L_CX) : '0;
  assign o_sy  = o_hit ? SYW'(i_wy - L_CY) : '0;

  // Slot state: eat, animate or count down to respawn on tick.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_alive <= 1'b1;
      r_frame <= '0;
      r_hold  <= '0;
      r_resp  <= '0;
    end else if (i_tick) begin
      if (r_alive) begin
        if (w_ov) begin
          r_alive <= 1'b0;
          r_frame <= '0;
          r_hold  <= '0;
          r_resp  <= '0;
        end else if (r_hold == L_HMAX) begin
          r_hold  <= '0;
          r_frame <= (r_frame == L_FMAX) ? '0 : r_frame + 1'b1;
        end else begin
          r_hold <= r_hold + 8'd1;
        end
      end else if (RESPAWN_TICKS != 0) begin
        if (r_resp == L_RMAX) begin
          r_alive <= 1'b1;
          r_resp  <= '0;
        end else begin
          r_resp <= r_resp + 16'd1;
        end
      end
    end
  end

endmodule

// File: rtl/coin_array.sv
// Row of collectible spinning coins: frame tick, scoring,
// and lowest-index-wins pixel selection for the renderer.
module coin_array
  import coin_pkg::*;
#(
  parameter int N_COINS       = 4,
  parameter int N_FRAMES      = 3,
  parameter int FRAME_HOLD    = 4,
  parameter int RESPAWN_TICKS = 0,
  parameter int COIN_X_BASE   = 400,
  parameter int COIN_SPACING  = 40,
  parameter int COIN_Y        = 300,
  parameter int COIN_W        = COIN_W_D,
  parameter int COIN_H        = COIN_H_D,
  parameter int PLAYER_W      = PLAYER_W_D,
  parameter int PLAYER_H      = PLAYER_H_D,
  localparam int SW  = (N_COINS > 1) ? $clog2(N_COINS) : 1,
  localparam int FW  = $clog2(N_FRAMES),
  localparam int SXW = $clog2(COIN_W),
  localparam int SYW = $clog2(COIN_H)
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_clk,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  input  logic [9:0]         process,
  input  logic [9:0]         player_x,
  input  logic [9:0]         player_y,
  output logic               coin_on,
  output logic [SW-1:0]      coin_sel,
  output logic [FW-1:0]      coin_frame,
  output logic [SXW-1:0]     sprite_x,
  output logic [SYW-1:0]     sprite_y,
  output logic [N_COINS-1:0] alive_mask,
  output logic               eat_pulse,
  output logic [7:0]         score
);

  logic        r_fc;
  logic        r_fc_q;
  logic        r_eat_pulse;
  logic [7:0]  r_score;

  logic               w_tick;
  logic [10:0]        w_wx;
  logic [10:0]        w_wy;
  logic [7:0]         w_cnt;
  logic [N_COINS-1:0] w_alive;
  logic [N_COINS-1:0] w_eat;
  logic [N_COINS-1:0] w_hit;
  logic [FW-1:0]      w_frame [N_COINS];
  logic [SXW-1:0]     w_sx    [N_COINS];
  logic [SYW-1:0]     w_sy    [N_COINS];

  assign w_tick = r_fc & ~r_fc_q;
  assign w_wx   = {1'b0, DrawX} + {1'b0, process};
  assign w_wy   = {1'b0, DrawY};

  for (genvar g = 0; g < N_COINS; g++) begin : g_slot
    coin_slot #(
      .N_FRAMES      (N_FRAMES),
      .FRAME_HOLD    (FRAME_HOLD),
      .RESPAWN_TICKS (RESPAWN_TICKS),
      .CX            (COIN_X_BASE + g * COIN_SPACING),
      .COIN_Y        (COIN_Y),
      .COIN_W        (COIN_W),
      .COIN_H        (COIN_H),
      .PLAYER_W      (PLAYER_W),
      .PLAYER_H      (PLAYER_H),
      .FW            (FW),
      .SXW           (SXW),
      .SYW           (SYW)
    ) u_slot (
      .i_clk   (Clk),
      .i_rst   (Reset),
      .i_tick  (w_tick),
      .i_px    (player_x),
      .i_py    (player_y),
      .i_wx    (w_wx),
      .i_wy    (w_wy),
      .o_alive (w_alive[g]),
      .o_frame (w_frame[g]),
      .o_eat   (w_eat[g]),
      .o_hit   (w_hit[g]),
      .o_sx    (w_sx[g]),
      .o_sy    (w_sy[g])
    );
  end

  // Number of slots eaten on the current tick.
  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < N_COINS; i++) begin
      w_cnt = w_cnt + 8'(w_eat[i]);
    end
  end

  // Frame strobe edge detect, score and eat pulse.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_fc        <= 1'b0;
      r_fc_q      <= 1'b0;
      r_eat_pulse <= 1'b0;
      r_score     <= '0;
    end else begin
      r_fc        <= frame_clk;
      r_fc_q      <= r_fc;
      r_eat_pulse <= |w_eat;
      if (|w_eat) begin
        r_score <= sat_add8(r_score, w_cnt);
      end
    end
  end

  // Pixel mux: scan downward so the lowest live index wins.
  always_comb begin
    coin_on    = 1'b0;
    coin_sel   = '0;
    coin_frame = '0;
    sprite_x   = '0;
    sprite_y   = '0;
    for (int i = N_COINS - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        coin_on    = 1'b1;
        coin_sel   = SW'(i);
        coin_frame = w_frame[i];
        sprite_x   = w_sx[i];
        sprite_y   = w_sy[i];
      end
    end
  end

  assign alive_mask = w_alive;
  assign eat_pulse  = r_eat_pulse;
  assign score      = r_score;

endmodule

// File: tb/tb_coin_array.sv
// Self-checking bench for coin_array: directed scenarios plus
// randomized play compared against an age-based behavioural model.
module tb_coin_array;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic [9:0] DrawX = '0;
  logic [9:0] DrawY = '0;
  logic [9:0] process = '0;
  logic [9:0] px [3];
  logic [9:0] py [3];

  logic       on  [3];
  logic [1:0] sel [3];
  logic [1:0] frm [3];
  logic [3:0] sx  [3];
  logic [4:0] sy  [3];
  logic [3:0] am  [3];
  logic       ep  [3];
  logic [7:0] sc  [3];

  int checks = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  coin_array u_dut0 (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
    .DrawX(DrawX), .DrawY(DrawY), .process(process),
    .player_x(px[0]), .player_y(py[0]),
    .coin_on(on[0]), .coin_sel(sel[0]), .coin_frame(frm[0]),
    .sprite_x(sx[0]), .sprite_y(sy[0]),
    .alive_mask(am[0]), .eat_pulse(ep[0]), .score(sc[0])
  );

  coin_array #(.COIN_SPACING(8)) u_dut1 (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
    .DrawX(DrawX), .DrawY(DrawY), .process(process),
    .player_x(px[1]), .player_y(py[1]),
    .coin_on(on[1]), .coin_sel(sel[1]), .coin_frame(frm[1]),
    .sprite_x(sx[1]), .sprite_y(sy[1]),
    .alive_mask(am[1]), .eat_pulse(ep[1]), .score(sc[1])
  );

  coin_array #(.RESPAWN_TICKS(3)) u_dut2 (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
    .DrawX(DrawX), .DrawY(DrawY), .process(process),
    .player_x(px[2]), .player_y(py[2]),
    .coin_on(on[2]), .coin_sel(sel[2]), .coin_frame(frm[2]),
    .sprite_x(sx[2]), .sprite_y(sy[2]),
    .alive_mask(am[2]), .eat_pulse(ep[2]), .score(sc[2])
  );

  // Model: per slot, ticks lived since (re)spawn and ticks dead.
  int sp [3] = '{40, 8, 40};
  int rt [3] = '{0, 0, 3};
  bit m_alive [3][4];
  int m_age   [3][4];
  int m_dage  [3][4];
  int m_score [3];
  int m_eaten [3];

  function automatic void m_reset();
    for (int k = 0; k < 3; k++) begin
      m_score[k] = 0;
      m_eaten[k] = 0;
      for (int i = 0; i < 4; i++) begin
        m_alive[k][i] = 1'b1;
        m_age[k][i] = 0;
        m_dage[k][i] = 0;
      end
    end
  endfunction

  function automatic bit hits_player(int k, int i);
    int cx, x, y;
    cx = 400 + i * sp[k];
    x = int'(px[k]);
    y = int'(py[k]);
    return (cx < x + 16) && (x < cx + 16)
        && (300 < y + 32) && (y < 328);
  endfunction

  function automatic void m_tick();
    for (int k = 0; k < 3; k++) begin
      m_eaten[k] = 0;
      for (int i = 0; i < 4; i++) begin
        if (m_alive[k][i]) begin
          if (hits_player(k, i)) begin
            m_alive[k][i] = 1'b0;
            m_dage[k][i] = 0;
            m_eaten[k]++;
          end else begin
            m_age[k][i]++;
          end
        end else if (rt[k] > 0) begin
          m_dage[k][i]++;
          if (m_dage[k][i] == rt[k]) begin
            m_alive[k][i] = 1'b1;
            m_age[k][i] = 0;
          end
        end
      end
      m_score[k] = m_score[k] + m_eaten[k];
      if (m_score[k] > 255) m_score[k] = 255;
    end
  endfunction

  function automatic int m_mask(int k);
    int m;
    m = 0;
    for (int i = 0; i < 4; i++) if (m_alive[k][i]) m |= (1 << i);
    return m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pix_chk(input int k, input string tag);
    int wx, wy, e_on, e_sel, e_frm, e_sx, e_sy, cx;
    wx = (int'(DrawX) + int'(process)) % 2048;
    wy = int'(DrawY);
    e_on = 0; e_sel = 0; e_frm = 0; e_sx = 0; e_sy = 0;
    for (int i = 3; i >= 0; i--) begin
      cx = 400 + i * sp[k];
      if (m_alive[k][i] && wx >= cx && wx < cx + 16
          && wy >= 300 && wy < 328) begin
        e_on = 1;
        e_sel = i;
        e_frm = (m_age[k][i] / 4) % 3;
        e_sx = wx - cx;
        e_sy = wy - 300;
      end
    end
    #1;
    chk({tag, "_on"},  32'(on[k]),  32'(e_on));
    chk({tag, "_sel"}, 32'(sel[k]), 32'(e_sel));
    chk({tag, "_frm"}, 32'(frm[k]), 32'(e_frm));
    chk({tag, "_sx"},  32'(sx[k]),  32'(e_sx));
    chk({tag, "_sy"},  32'(sy[k]),  32'(e_sy));
  endtask

  task automatic set_pix(input int x, input int y, input int p);
    DrawX = 10'(x);
    DrawY = 10'(y);
    process = 10'(p);
    #1;
  endtask

  task automatic do_tick();
    @(negedge Clk) frame_clk = 1'b1;
    @(negedge Clk);
    m_tick();
    @(negedge Clk);
    for (int k = 0; k < 3; k++)
      chk($sformatf("pulse_hi%0d", k), 32'(ep[k]),
          32'(m_eaten[k] > 0));
    frame_clk = 1'b0;
    @(negedge Clk);
    for (int k = 0; k < 3; k++)
      chk($sformatf("pulse_lo%0d", k), 32'(ep[k]), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge Clk) Reset = 1'b1;
    frame_clk = 1'b0;
    @(negedge Clk);
    @(negedge Clk) Reset = 1'b0;
    m_reset();
  endtask

  int fexp [12] = '{0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 0};
  int post_eat;
  int pick;
  int cands [$];

  initial begin
    for (int k = 0; k < 3; k++) begin
      px[k] = '0;
      py[k] = '0;
    end
    m_reset();
    do_reset();

    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_mask%0d", k), 32'(am[k]), 32'hF);
      chk($sformatf("rst_score%0d", k), 32'(sc[k]), 32'd0);
      chk($sformatf("rst_pulse%0d", k), 32'(ep[k]), 32'd0);
    end

    set_pix(400, 300, 0);
    chk("edge_x400_on", 32'(on[0]), 32'd1);
    chk("edge_x400_sx", 32'(sx[0]), 32'd0);
    set_pix(415, 300, 0);
    chk("edge_x415_on", 32'(on[0]), 32'd1);
    chk("edge_x415_sx", 32'(sx[0]), 32'd15);
    set_pix(416, 300, 0);
    chk("edge_x416_on", 32'(on[0]), 32'd0);
    chk("edge_x416_sx", 32'(sx[0]), 32'd0);
    set_pix(400, 327, 0);
    chk("edge_y327_on", 32'(on[0]), 32'd1);
    chk("edge_y327_sy", 32'(sy[0]), 32'd27);
    set_pix(400, 328, 0);
    chk("edge_y328_on", 32'(on[0]), 32'd0);
    set_pix(300, 300, 100);
    chk("scroll_on", 32'(on[0]), 32'd1);
    chk("scroll_sx", 32'(sx[0]), 32'd0);

    set_pix(400, 300, 0);
    for (int t = 0; t < 12; t++) begin
      do_tick();
      chk($sformatf("anim_t%0d", t + 1), 32'(frm[0]), 32'(fexp[t]));
      pix_chk(0, "anim_pix");
    end
    chk("anim_score", 32'(sc[0]), 32'd0);

    px[0] = 10'd392;
    py[0] = 10'd290;
    do_tick();
    chk("eat1_mask", 32'(am[0]), 32'hE);
    chk("eat1_score", 32'(sc[0]), 32'd1);
    px[0] = '0;
    py[0] = '0;

    px[1] = 10'd396;
    py[1] = 10'd290;
    set_pix(410, 310, 0);
    chk("two_pre410_sel", 32'(sel[1]), 32'd0);
    pix_chk(1, "two_pre410");
    set_pix(418, 310, 0);
    chk("two_pre418_sel", 32'(sel[1]), 32'd1);
    do_tick();
    chk("two_score", 32'(sc[1]), 32'd2);
    chk("two_mask", 32'(am[1]), 32'hC);
    chk("two_post418_sel", 32'(sel[1]), 32'd2);
    set_pix(410, 310, 0);
    pix_chk(1, "two_post410");
    px[1] = '0;
    py[1] = '0;

    px[2] = 10'd392;
    py[2] = 10'd290;
    do_tick();
    chk("resp_eat", 32'(am[2]), 32'hE);
    px[2] = '0;
    py[2] = '0;
    do_tick();
    chk("resp_t1", 32'(am[2][0]), 32'd0);
    do_tick();
    chk("resp_t2", 32'(am[2][0]), 32'd0);
    do_tick();
    chk("resp_t3", 32'(am[2][0]), 32'd1);
    set_pix(400, 300, 0);
    chk("resp_frame", 32'(frm[2]), 32'd0);
    chk("resp_on", 32'(on[2]), 32'd1);

    post_eat = 0;
    for (int n = 0; n < 1500 && post_eat < 2; n++) begin
      cands.delete();
      for (int i = 0; i < 4; i++) if (m_alive[2][i]) cands.push_back(i);
      if (cands.size() > 0 && $urandom_range(0, 7) != 0) begin
        pick = cands[$urandom_range(0, cands.size() - 1)];
        px[2] = 10'(400 + pick * 40 - 15 + $urandom_range(0, 30));
        py[2] = 10'(269 + $urandom_range(0, 58));
      end else begin
        px[2] = 10'($urandom_range(0, 1023));
        py[2] = 10'($urandom_range(0, 1023));
      end
      if (m_score[2] == 255) post_eat = post_eat + 0;
      pick = m_score[2];
      do_tick();
      if (pick == 255 && m_eaten[2] > 0) post_eat++;
      chk("rnd_mask", 32'(am[2]), 32'(m_mask(2)));
      chk("rnd_score", 32'(sc[2]), 32'(m_score[2]));
      set_pix($urandom_range(0, 639), $urandom_range(290, 335),
              $urandom_range(0, 200));
      pix_chk(2, "rnd_pix2");
      pix_chk(0, "rnd_pix0");
    end
    chk("score_sat", 32'(sc[2]), 32'd255);
    px[2] = '0;
    py[2] = '0;

    do_reset();
    px[0] = 10'd392;
    py[0] = 10'd290;
    @(negedge Clk) frame_clk = 1'b1;
    @(negedge Clk) Reset = 1'b1;
    @(negedge Clk) Reset = 1'b0;
    frame_clk = 1'b0;
    m_reset();
    chk("rsttick_mask", 32'(am[0]), 32'hF);
    chk("rsttick_score", 32'(sc[0]), 32'd0);
    chk("rsttick_pulse", 32'(ep[0]), 32'd0);
    @(negedge Clk);
    @(negedge Clk);
    chk("rsttick_pulse2", 32'(ep[0]), 32'd0);
    chk("rsttick_mask2", 32'(am[0]), 32'hF);
    chk("rsttick_score2", 32'(sc[0]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
